// File: rtl/wishbone_dmi_if.sv
// Signal bundle between a DMI requester, the Wishbone DMI master and the
// Wishbone slave. The master modport is the bridge's view; slave is the environment's.
interface wishbone_dmi_if;
  logic        req_valid_i;
  logic        req_ready_o;
  logic [1:0]  req_op_i;
  logic [6:0]  req_addr_i;
  logic [63:0] req_data_i;
  logic        rsp_valid_o;
  logic        rsp_ready_i;
  logic [63:0] rsp_data_o;
  logic [1:0]  rsp_status_o;
  logic [31:0] addr_o;
  logic        we_o;
  logic        cyc_o;
  logic        stb_o;
  logic [63:0] data_o;
  logic [63:0] data_i;
  logic        ack_i;

  modport master (
    input  req_valid_i, req_op_i, req_addr_i, req_data_i, rsp_ready_i, data_i, ack_i,
    output req_ready_o, rsp_valid_o, rsp_data_o, rsp_status_o,
           addr_o, we_o, cyc_o, stb_o, data_o
  );

  modport slave (
    output req_valid_i, req_op_i, req_addr_i, req_data_i, rsp_ready_i, data_i, ack_i,
    input  req_ready_o, rsp_valid_o, rsp_data_o, rsp_status_o,
           addr_o, we_o, cyc_o, stb_o, data_o
  );
endinterface

// File: rtl/wishbone_dmi_master.sv
// Turns one DMI request at a time into a single Wishbone cycle, waits for the
// slave to release ack, and returns data/status; a stalled cycle times out.
module wishbone_dmi_master #(
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic           clk_i,
  input  logic           rst_i,
  wishbone_dmi_if.master bus
);
  localparam logic [1:0]  OP_NOP        = 2'd0;
  localparam logic [1:0]  OP_WRITE      = 2'd2;
  localparam logic [1:0]  OP_RSVD       = 2'd3;
  localparam logic [1:0]  ST_OK         = 2'd0;
  localparam logic [1:0]  ST_FAIL       = 2'd2;
  localparam logic [15:0] TIMEOUT_LIMIT = 16'(TIMEOUT_CYCLES);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    CYCLE = 2'd1,
    DRAIN = 2'd2,
    RESP  = 2'd3
  } state_e;

  state_e      state_q, state_d;
  logic [15:0] cnt_q, cnt_d;
  logic        ready_q, ready_d;
  logic        cyc_q, cyc_d;
  logic        we_q, we_d;
  logic [6:0]  addr_q, addr_d;
  logic [63:0] wdata_q, wdata_d;
  logic [63:0] rsp_data_q, rsp_data_d;
  logic [1:0]  status_q, status_d;

  // Every output is a flop cleared by reset, so a reset drops cyc_o at once.
  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      ready_q    <= 1'b0;
      cyc_q      <= 1'b0;
      we_q       <= 1'b0;
      addr_q     <= '0;
      wdata_q    <= '0;
      rsp_data_q <= '0;
      status_q   <= ST_OK;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      ready_q    <= ready_d;
      cyc_q      <= cyc_d;
      we_q       <= we_d;
      addr_q     <= addr_d;
      wdata_q    <= wdata_d;
      rsp_data_q <= rsp_data_d;
      status_q   <= status_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    cyc_d      = cyc_q;
    we_d       = we_q;
    addr_d     = addr_q;
    wdata_d    = wdata_q;
    rsp_data_d = rsp_data_q;
    status_d   = status_q;

    unique case (state_q)
      IDLE: begin
        if (ready_q && bus.req_valid_i) begin
          addr_d  = bus.req_addr_i;
          wdata_d = bus.req_data_i;
          case (bus.req_op_i)
            OP_NOP: begin
              state_d    = RESP;
              rsp_data_d = '0;
              status_d   = ST_OK;
            end
            OP_RSVD: begin
              state_d    = RESP;
              rsp_data_d = '0;
              status_d   = ST_FAIL;
            end
            default: begin
              state_d = CYCLE;
              cnt_d   = '0;
              cyc_d   = 1'b1;
              we_d    = (bus.req_op_i == OP_WRITE);
            end
          endcase
        end
      end
      CYCLE: begin
        // An ack on the same edge as the timeout still completes the transfer.
        if (bus.ack_i) begin
          state_d    = DRAIN;
          cyc_d      = 1'b0;
          we_d       = 1'b0;
          rsp_data_d = bus.data_i;
          status_d   = ST_OK;
        end else begin
          cnt_d = cnt_q + 16'd1;
          if (cnt_d == TIMEOUT_LIMIT) begin
            state_d    = RESP;
            cyc_d      = 1'b0;
            we_d       = 1'b0;
            rsp_data_d = '0;
            status_d   = ST_FAIL;
          end
        end
      end
      DRAIN: begin
        if (!bus.ack_i) state_d = RESP;
      end
      RESP: begin
        if (bus.rsp_ready_i) state_d = IDLE;
      end
    endcase
  end

  // Registered so ready rises only on the first edge after reset or response.
  assign ready_d = (state_d == IDLE);

  assign bus.req_ready_o  = ready_q;
  assign bus.rsp_valid_o  = (state_q == RESP);
  assign bus.rsp_data_o   = rsp_data_q;
  assign bus.rsp_status_o = status_q;
  assign bus.addr_o       = {25'd0, addr_q};
  assign bus.data_o       = wdata_q;
  assign bus.we_o         = we_q;
  assign bus.cyc_o        = cyc_q;
  assign bus.stb_o        = cyc_q;
endmodule

// File: tb/tb_wishbone_dmi_master.sv
// Bench for wishbone_dmi_master: transaction-level register-file model of the
// Wishbone slave, directed scenarios plus randomized traffic.
module tb_wishbone_dmi_master;
  localparam int TO = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;

  wishbone_dmi_if bus ();

  wishbone_dmi_master #(.TIMEOUT_CYCLES(TO)) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  always #5 clk = ~clk;

  // Model: slave register file and the transaction currently in flight.
  logic [63:0] mem [128];
  logic        m_bus       = 1'b0;
  logic        m_we        = 1'b0;
  logic        m_rsp_known = 1'b0;
  logic [6:0]  m_addr      = '0;
  logic [63:0] m_wdata     = '0;
  logic [63:0] m_rsp_data  = '0;
  logic [1:0]  m_rsp_st    = '0;

  int cmp_n = 0;
  int err_n = 0;

  // Driver-side expectations are queued here and compared by the monitor.
  string       pn [64];
  logic [63:0] pg [64];
  logic [63:0] pe [64];
  int          wr_idx = 0;
  int          rd_idx = 0;

  task automatic chk(input string nm, input logic [63:0] got, input logic [63:0] exp);
    cmp_n++;
    if (got !== exp) begin
      err_n++;
      $display("FAIL %s: got 0x%0h, required 0x%0h", nm, got, exp);
    end
  endtask

  task automatic post(input string nm, input logic [63:0] got, input logic [63:0] exp);
    pn[wr_idx % 64] = nm;
    pg[wr_idx % 64] = got;
    pe[wr_idx % 64] = exp;
    wr_idx++;
  endtask

  always @(negedge clk) begin
    while (rd_idx < wr_idx) begin
      chk(pn[rd_idx % 64], pg[rd_idx % 64], pe[rd_idx % 64]);
      rd_idx++;
    end
    if (rst) begin
      chk("reset_ctrl", {59'd0, bus.req_ready_o, bus.rsp_valid_o, bus.cyc_o, bus.stb_o, bus.we_o}, 64'd0);
      chk("reset_data", {63'd0, (|bus.addr_o) | (|bus.data_o) | (|bus.rsp_data_o) | (|bus.rsp_status_o)}, 64'd0);
    end else begin
      chk("cyc_eq_stb", 64'(bus.stb_o), 64'(bus.cyc_o));
      if (bus.cyc_o) begin
        chk("cyc_allowed", 64'(m_bus), 64'd1);
        chk("addr_o", 64'(bus.addr_o), {57'd0, m_addr});
        chk("we_o", 64'(bus.we_o), 64'(m_we));
        if (m_we) chk("data_o", bus.data_o, m_wdata);
        chk("ready_in_cycle", 64'(bus.req_ready_o), 64'd0);
      end
      if (bus.rsp_valid_o) begin
        chk("rsp_expected", 64'(m_rsp_known), 64'd1);
        chk("rsp_data", bus.rsp_data_o, m_rsp_data);
        chk("rsp_status", 64'(bus.rsp_status_o), 64'(m_rsp_st));
        chk("ready_in_resp", 64'(bus.req_ready_o), 64'd0);
      end
    end
  end

  task automatic scramble_req();
    bus.req_valid_i = 1'($urandom_range(0, 1));
    bus.req_op_i    = 2'($urandom_range(0, 3));
    bus.req_addr_i  = 7'($urandom_range(0, 127));
    bus.req_data_i  = {$urandom(), $urandom()};
  endtask

  // One full request/response. ack_lat: CYCLE clocks before ack (>= TO means
  // never); hold: extra clocks ack stays high after cyc drops; rdy_dly: clocks
  // rsp_ready_i is held low in RESP.
  task automatic do_txn(input logic [1:0] op, input logic [6:0] a, input logic [63:0] d,
                        input int ack_lat, input int hold, input int rdy_dly,
                        output logic [63:0] r_data, output logic [1:0] r_st,
                        output int n_cyc, output int n_drain);
    bit bus_op;
    bit acked;
    int guard;
    bus_op  = (op == 2'd1) || (op == 2'd2);
    acked   = bus_op && (ack_lat < TO);
    n_cyc   = 0;
    n_drain = 0;
    guard   = 0;
    m_addr     = a;
    m_we       = (op == 2'd2);
    m_wdata    = d;
    m_rsp_data = acked ? mem[a] : 64'd0;
    m_rsp_st   = (op == 2'd3 || (bus_op && !acked)) ? 2'd2 : 2'd0;
    while (!bus.req_ready_o && guard < 20) begin
      @(posedge clk); #1;
      guard++;
    end
    post("ready_idle", 64'(bus.req_ready_o), 64'd1);
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = op;
    bus.req_addr_i  = a;
    bus.req_data_i  = d;
    @(posedge clk); #1;
    m_bus       = bus_op;
    m_rsp_known = 1'b1;
    if (bus_op) begin
      while (bus.cyc_o && n_cyc < TO + 4) begin
        scramble_req();
        bus.ack_i  = (n_cyc == ack_lat);
        bus.data_i = bus.ack_i ? m_rsp_data : {$urandom(), $urandom()};
        n_cyc++;
        @(posedge clk); #1;
      end
      m_bus = 1'b0;
      post("cyc_len", 64'(n_cyc), acked ? 64'(ack_lat + 1) : 64'(TO));
      if (acked) begin
        if (op == 2'd2) mem[a] = d;
        while (!bus.rsp_valid_o && n_drain < hold + 4) begin
          bus.ack_i  = (n_drain < hold);
          bus.data_i = {$urandom(), $urandom()};
          n_drain++;
          @(posedge clk); #1;
        end
        post("drain_len", 64'(n_drain), 64'(hold + 1));
      end
    end else begin
      scramble_req();
    end
    post("rsp_valid", 64'(bus.rsp_valid_o), 64'd1);
    post("no_cyc_in_resp", 64'(bus.cyc_o), 64'd0);
    r_data = bus.rsp_data_o;
    r_st   = bus.rsp_status_o;
    for (int i = 0; i < rdy_dly; i++) begin
      bus.ack_i = 1'($urandom_range(0, 1));
      scramble_req();
      @(posedge clk); #1;
      post("rsp_held", 64'(bus.rsp_valid_o), 64'd1);
    end
    bus.rsp_ready_i = 1'b1;
    @(posedge clk); #1;
    bus.rsp_ready_i = 1'b0;
    bus.req_valid_i = 1'b0;
    bus.ack_i       = 1'b0;
    m_rsp_known     = 1'b0;
    post("rsp_released", 64'(bus.rsp_valid_o), 64'd0);
    post("ready_after_rsp", 64'(bus.req_ready_o), 64'd1);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within the time limit");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [63:0] rd;
    logic [1:0]  st;
    int          nc;
    int          nd;
    logic [1:0]  op;
    logic [6:0]  a;
    logic [63:0] d;

    for (int i = 0; i < 128; i++) mem[i] = 64'd0;
    bus.req_valid_i = 1'b0;
    bus.req_op_i    = 2'd0;
    bus.req_addr_i  = 7'd0;
    bus.req_data_i  = 64'd0;
    bus.rsp_ready_i = 1'b0;
    bus.data_i      = 64'd0;
    bus.ack_i       = 1'b0;

    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    #1 post("ready_before_first_edge", 64'(bus.req_ready_o), 64'd0);
    @(posedge clk); #1;
    post("ready_first_edge", 64'(bus.req_ready_o), 64'd1);

    do_txn(2'd2, 7'h10, 64'h8000_0000, 2, 0, 0, rd, st, nc, nd);
    post("w10_status", 64'(st), 64'd0);
    do_txn(2'd1, 7'h10, 64'd0, 1, 0, 0, rd, st, nc, nd);
    post("r10_data", rd, 64'h8000_0000);
    post("r10_status", 64'(st), 64'd0);

    do_txn(2'd2, 7'h04, 64'h1234, 0, 0, 1, rd, st, nc, nd);
    do_txn(2'd1, 7'h04, 64'd0, 3, 0, 0, rd, st, nc, nd);
    post("r04_data", rd, 64'h1234);
    post("r04_single_pulse_len", 64'(nc), 64'd4);

    do_txn(2'd1, 7'h04, 64'd0, 100, 0, 0, rd, st, nc, nd);
    post("timeout_cyc_len", 64'(nc), 64'd8);
    post("timeout_status", 64'(st), 64'd2);
    post("timeout_data", rd, 64'd0);

    do_txn(2'd1, 7'h10, 64'd0, TO - 1, 0, 0, rd, st, nc, nd);
    post("ack_at_limit_status", 64'(st), 64'd0);
    post("ack_at_limit_data", rd, 64'h8000_0000);

    do_txn(2'd1, 7'h04, 64'd0, 0, 3, 0, rd, st, nc, nd);
    post("drain3_len", 64'(nd), 64'd4);
    post("drain3_data", rd, 64'h1234);

    do_txn(2'd0, 7'h22, 64'hdead_beef, 0, 0, 0, rd, st, nc, nd);
    post("nop_status", 64'(st), 64'd0);
    post("nop_data", rd, 64'd0);
    do_txn(2'd3, 7'h22, 64'hdead_beef, 0, 0, 0, rd, st, nc, nd);
    post("rsvd_status", 64'(st), 64'd2);
    post("rsvd_data", rd, 64'd0);
    post("rsvd_no_cycle", 64'(nc), 64'd0);

    do_txn(2'd1, 7'h10, 64'd0, 1, 0, 5, rd, st, nc, nd);
    post("resp_hold_data", rd, 64'h8000_0000);

    // Reset in the middle of a stalled read.
    m_addr  = 7'h10;
    m_we    = 1'b0;
    m_wdata = 64'd0;
    bus.req_valid_i = 1'b1;
    bus.req_op_i    = 2'd1;
    bus.req_addr_i  = 7'h10;
    bus.req_data_i  = 64'd0;
    @(posedge clk); #1;
    bus.req_valid_i = 1'b0;
    m_bus = 1'b1;
    repeat (3) @(posedge clk);
    #3 post("cyc_before_rst", 64'(bus.cyc_o), 64'd1);
    rst = 1'b1;
    #1;
    post("rst_drops_bus", {61'd0, bus.cyc_o, bus.stb_o, bus.we_o}, 64'd0);
    post("rst_no_rsp", 64'(bus.rsp_valid_o), 64'd0);
    post("rst_ready_low", 64'(bus.req_ready_o), 64'd0);
    m_bus = 1'b0;
    @(posedge clk);
    #3 rst = 1'b0;
    #1 post("ready_low_until_edge", 64'(bus.req_ready_o), 64'd0);
    @(posedge clk); #1;
    post("ready_after_rst_edge", 64'(bus.req_ready_o), 64'd1);
    post("no_rsp_after_rst", 64'(bus.rsp_valid_o), 64'd0);

    for (int t = 0; t < 150; t++) begin
      op = 2'($urandom_range(0, 3));
      a  = 7'($urandom_range(0, 7));
      d  = {$urandom(), $urandom()};
      do_txn(op, a, d, int'($urandom_range(0, TO + 1)), int'($urandom_range(0, 3)),
             int'($urandom_range(0, 3)), rd, st, nc, nd);
    end

    repeat (2) @(negedge clk);
    #1;
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", cmp_n, err_n);
    $finish;
  end
endmodule
